// File: rtl/alarm_ctrl.sv
// Alarm sequencing controller: holds the programmed alarm time, watches the
// time-of-day and runs the ring / snooze / stop FSM driving the tone enable.
module alarm_ctrl #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic       arm,
  input  logic       set_alarm,
  input  logic [4:0] set_hr,
  input  logic [5:0] set_min,
  input  logic       snooze,
  input  logic       stop,
  output logic       ring_en,
  output logic [4:0] alarm_hr,
  output logic [5:0] alarm_min,
  output logic [1:0] snooze_cnt,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZED = 2'd3
  } state_t;

  localparam int CNT_W = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] ring_cnt_q, ring_cnt_nxt;
  logic [1:0]       snooze_cnt_q, snooze_cnt_nxt;
  logic [4:0]       alarm_hr_q, alarm_hr_nxt;
  logic [5:0]       alarm_min_q, alarm_min_nxt;
  logic [4:0]       snz_hr_q, snz_hr_nxt;
  logic [5:0]       snz_min_q, snz_min_nxt;
  logic             alarm_match_q, snz_match_q;
  logic             ring_en_q;
  logic             set_ok, snz_latch;
  logic             alarm_match, snz_match, alarm_hit, snz_hit;
  logic             alarm_match_nxt, snz_match_nxt;
  logic [10:0]      snz_tgt;

  // Current time plus the snooze interval, minutes mod 60 with hour carry mod 24.
  function automatic logic [10:0] add_snooze(input logic [4:0] hr, input logic [5:0] mn);
    logic [6:0] m;
    logic [4:0] h;
    m = {1'b0, mn} + 7'(SNOOZE_MIN);
    h = hr;
    if (m >= 7'd60) begin
      m = m - 7'd60;
      h = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
    end
    return {h, m[5:0]};
  endfunction

  assign set_ok        = set_alarm && (set_hr < 5'd24) && (set_min < 6'd60);
  assign alarm_hr_nxt  = set_ok ? set_hr  : alarm_hr_q;
  assign alarm_min_nxt = set_ok ? set_min : alarm_min_q;
  assign snz_tgt       = add_snooze(cur_hr, cur_min);
  assign snz_hr_nxt    = snz_latch ? snz_tgt[10:6] : snz_hr_q;
  assign snz_min_nxt   = snz_latch ? snz_tgt[5:0]  : snz_min_q;

  assign alarm_match = (cur_hr == alarm_hr_q) && (cur_min == alarm_min_q) && (cur_sec == 6'd0);
  assign snz_match   = (cur_hr == snz_hr_q) && (cur_min == snz_min_q) && (cur_sec == 6'd0);
  assign alarm_hit   = alarm_match && !alarm_match_q;
  assign snz_hit     = snz_match && !snz_match_q;

  // History is taken against the value the target will hold next cycle, so a
  // load made during the matching second never presents a rising edge.
  assign alarm_match_nxt = (cur_hr == alarm_hr_nxt) && (cur_min == alarm_min_nxt) && (cur_sec == 6'd0);
  assign snz_match_nxt   = (cur_hr == snz_hr_nxt) && (cur_min == snz_min_nxt) && (cur_sec == 6'd0);

  always_comb begin
    state_nxt      = state_q;
    ring_cnt_nxt   = ring_cnt_q;
    snooze_cnt_nxt = snooze_cnt_q;
    snz_latch      = 1'b0;
    if (!arm) begin
      state_nxt      = IDLE;
      ring_cnt_nxt   = '0;
      snooze_cnt_nxt = 2'd0;
    end else if (set_ok) begin
      state_nxt      = ARMED;
      ring_cnt_nxt   = '0;
      snooze_cnt_nxt = 2'd0;
    end else begin
      case (state_q)
        IDLE:  state_nxt = ARMED;
        ARMED: begin
          if (alarm_hit) begin
            state_nxt    = RINGING;
            ring_cnt_nxt = '0;
          end
        end
        RINGING: begin
          if (stop) begin
            state_nxt      = ARMED;
            snooze_cnt_nxt = 2'd0;
          end else if (snooze && (int'(snooze_cnt_q) < MAX_SNOOZE)) begin
            state_nxt      = SNOOZED;
            snooze_cnt_nxt = snooze_cnt_q + 2'd1;
            snz_latch      = 1'b1;
          end else if (sec_tick) begin
            if (ring_cnt_q == CNT_W'(RING_SECS - 1)) begin
              state_nxt      = ARMED;
              ring_cnt_nxt   = '0;
              snooze_cnt_nxt = 2'd0;
            end else begin
              ring_cnt_nxt = ring_cnt_q + 1'b1;
            end
          end
        end
        SNOOZED: begin
          if (stop) begin
            state_nxt      = ARMED;
            snooze_cnt_nxt = 2'd0;
          end else if (snz_hit) begin
            state_nxt    = RINGING;
            ring_cnt_nxt = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ring_cnt_q    <= '0;
      snooze_cnt_q  <= 2'd0;
      alarm_hr_q    <= 5'd0;
      alarm_min_q   <= 6'd0;
      snz_hr_q      <= 5'd0;
      snz_min_q     <= 6'd0;
      alarm_match_q <= 1'b0;
      snz_match_q   <= 1'b0;
      ring_en_q     <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      ring_cnt_q    <= ring_cnt_nxt;
      snooze_cnt_q  <= snooze_cnt_nxt;
      alarm_hr_q    <= alarm_hr_nxt;
      alarm_min_q   <= alarm_min_nxt;
      snz_hr_q      <= snz_hr_nxt;
      snz_min_q     <= snz_min_nxt;
      alarm_match_q <= alarm_match_nxt;
      snz_match_q   <= snz_match_nxt;
      ring_en_q     <= (state_nxt == RINGING);
    end
  end

  assign ring_en    = ring_en_q;
  assign alarm_hr   = alarm_hr_q;
  assign alarm_min  = alarm_min_q;
  assign snooze_cnt = snooze_cnt_q;
  assign state_o    = state_q;

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Alarm sequencing controller that sits directly upstream of the alarm tone generator and drives that block's enable input. It holds the programmed alarm time and compares it against the running time-of-day. It then runs the ring / snooze / stop state machine and asserts ring_en while the tone must sound.

Parameters:
RING_SECS, 60, ring duration in sec_tick pulses before auto-timeout (>=1)
SNOOZE_MIN, 5, snooze interval in minutes (1..59)
MAX_SNOOZE, 3, snoozes allowed per alarm event; further snooze requests ignored

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sec_tick  input  1  one-cycle pulse once per second
cur_hr  input  5  current hour, 0..23
cur_min  input  6  current minute, 0..59
cur_sec  input  6  current second, 0..59
arm  input  1  level; 1 = alarm armed
set_alarm  input  1  one-cycle strobe; load set_hr/set_min
set_hr  input  5  alarm hour to load
set_min  input  6  alarm minute to load
snooze  input  1  one-cycle pulse (debounced upstream)
stop  input  1  one-cycle pulse (debounced upstream)
ring_en  output  1  to tone generator enable; 1 while RINGING
alarm_hr  output  5  programmed alarm hour (display)
alarm_min  output  6  programmed alarm minute (display)
snooze_cnt  output  2  snoozes used in current event
state_o  output  2  IDLE=0, ARMED=1, RINGING=2, SNOOZED=3

Behaviour:
- Reset (async, rst_n=0): state IDLE, ring_en 0, alarm_hr 0, alarm_min 0, snooze_cnt 0, ring counter 0, snooze target 0:00, match history regs 0.
- set_alarm: loads set_hr/set_min only if set_hr<24 and set_min<60; otherwise ignored, no state change. A valid load in RINGING/SNOOZED returns to ARMED (IDLE if arm=0) and clears snooze_cnt.
- alarm_match = (cur_hr==alarm_hr && cur_min==alarm_min && cur_sec==0). snz_match uses the snooze target instead. Each has a registered copy updated every cycle in every state. A hit is the rising edge only (match && !match_q).
- Arming or loading during the matching second does not fire (no rising edge seen).
- Priority per cycle: rst_n > arm=0 > valid set_alarm > stop > snooze > match/timeout.
- arm=0 in any state -> IDLE next edge; ring counter and snooze_cnt cleared.
- IDLE: arm=1 -> ARMED.
- ARMED: alarm_match rising edge -> RINGING; ring counter cleared.
- RINGING: ring counter increments on sec_tick.
  - On sec_tick with counter==RING_SECS-1 -> ARMED; snooze_cnt cleared.
  - stop -> ARMED; snooze_cnt cleared.
  - snooze with snooze_cnt<MAX_SNOOZE -> SNOOZED; snooze_cnt+1; snooze target latched = cur time + SNOOZE_MIN. Minutes wrap mod 60 with hour carry, hour wraps mod 24 (23:58 + 5 -> 00:03).
  - snooze with snooze_cnt==MAX_SNOOZE: ignored, keeps ringing.
  - stop and snooze together: stop wins.
- SNOOZED: snz_match rising edge -> RINGING; ring counter cleared. stop -> ARMED; snooze_cnt cleared. snooze ignored.
- ring_en = registered decode of state==RINGING. Rises/falls on the same edge the state enters/leaves RINGING, i.e. one cycle after the triggering input cycle. No combinational input->output paths.
- alarm_hr/alarm_min update on the edge after a valid set_alarm.

Test Plan:
- Reset mid-RINGING: rst_n low -> ring_en 0 immediately, state_o 0; after release with arm=1 -> ARMED next edge.
- Load 07:30, arm=1; drive time to 07:30:00 -> ring_en 1 one cycle later. Hold, no input, RING_SECS=60 sec_ticks -> ring_en 0, state ARMED.
- Alarm 23:58 ringing, snooze at 23:58:10 -> SNOOZED, snooze_cnt=1. Time 00:03:00 -> RINGING again.
- Snooze 3 times, fourth snooze while ringing -> still RINGING, snooze_cnt=3. stop -> ARMED, snooze_cnt=0.
- stop and snooze same cycle while RINGING -> ARMED, snooze_cnt unchanged path (cleared to 0).
- arm raised at 07:30:00 (already matching) -> no ring. set_alarm with set_hr=24 -> alarm_hr/min unchanged. arm=0 during SNOOZED -> IDLE, no later ring.
